// File: rtl/hamming_serial_rx_if.sv
// Channel bundle for hamming_serial_rx: serial codeword bits in (valid/ready),
// corrected data word out (valid/ready) plus the corrected-word counter.
interface hamming_serial_rx_if #(
    parameter int P = 3
);
    localparam int N = (1 << P) - 1;
    localparam int K = N - P;

    logic         rx_bit;
    logic         rx_valid;
    logic         rx_ready;
    logic [K-1:0] data_out;
    logic [P-1:0] syndrome;
    logic         corrected;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  err_count;

    modport master (
        output rx_bit, rx_valid, out_ready,
        input  rx_ready, data_out, syndrome, corrected, out_valid, err_count
    );

    modport slave (
        input  rx_bit, rx_valid, out_ready,
        output rx_ready, data_out, syndrome, corrected, out_valid, err_count
    );
endinterface

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(2^P-1) receive stage: shifts in a codeword LSB first, single-error
// corrects it and presents the data word on a valid/ready output. HAMMING_ERR_COUNT_EN adds a corrected-word counter.
module hamming_serial_rx #(
    parameter int P = 3
) (
    input  logic               clk,
    input  logic               rst,
    hamming_serial_rx_if.slave bus
);
    localparam int N  = (1 << P) - 1;
    localparam int K  = N - P;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        ST_SHIFT = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic logic [P-1:0] calc_syndrome(input logic [N-1:0] word);
        logic [P-1:0] s;
        logic [N-1:0] w;
        s = {P{1'b0}};
        w = word;
        for (int i = 0; i < N; i++) begin
            if (w[0]) begin
                s = s ^ P'(i + 1);
            end else begin
                s = s;
            end
            w = w >> 1;
        end
        return s;
    endfunction

    function automatic logic [N-1:0] correct_word(input logic [N-1:0] word, input logic [P-1:0] s);
        logic [N-1:0] mask;
        mask = {{(N-1){1'b0}}, 1'b1} << (s - P'(1));
        if (s != {P{1'b0}}) begin
            return word ^ mask;
        end else begin
            return word;
        end
    endfunction

    // Data bits occupy every non-power-of-two position, lowest position -> data[0].
    function automatic logic [K-1:0] extract_data(input logic [N-1:0] word);
        logic [K-1:0] d;
        logic [N-1:0] w;
        d = {K{1'b0}};
        w = word;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d = {w[0], d[K-1:1]};
            end else begin
                d = d;
            end
            w = w >> 1;
        end
        return d;
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  sr_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          rx_ready_r;
    logic [K-1:0]  data_r;
    logic [P-1:0]  syn_r;
    logic          corr_r;
    logic          out_valid_r;

    logic          take_s;
    logic          drain_s;
    logic          free_s;
    logic          load_s;
    logic [N-1:0]  shifted_s;
    logic [N-1:0]  load_word_s;
    logic [N-1:0]  fixed_s;
    logic [P-1:0]  load_syn_s;

    assign take_s      = bus.rx_valid && rx_ready_r;
    assign shifted_s   = {bus.rx_bit, sr_r[N-1:1]};
    assign drain_s     = out_valid_r && bus.out_ready;
    assign free_s      = !out_valid_r || bus.out_ready;
    assign load_syn_s  = calc_syndrome(load_word_s);
    assign fixed_s     = correct_word(load_word_s, load_syn_s);

    // FSM state, ready flag, shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_SHIFT;
            rx_ready_r <= 1'b1;
            cnt_r      <= {CW{1'b0}};
            sr_r       <= {N{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= (state_nxt_s == ST_SHIFT);
            cnt_r      <= cnt_nxt_s;
            if (take_s) begin
                sr_r <= shifted_s;
            end else begin
                sr_r <= sr_r;
            end
        end
    end

    // Next state, counter and output-load decision; the word being completed
    // is the live shift in SHIFT and the parked register in HOLD.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        load_word_s = shifted_s;
        case (state_r)
            ST_SHIFT: begin
                if (take_s) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s = {CW{1'b0}};
                        if (free_s) begin
                            load_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_HOLD;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_HOLD: begin
                load_word_s = sr_r;
                cnt_nxt_s   = {CW{1'b0}};
                if (drain_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_SHIFT;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output register: load wins over drain so back-to-back words keep out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            data_r      <= {K{1'b0}};
            syn_r       <= {P{1'b0}};
            corr_r      <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            data_r      <= extract_data(fixed_s);
            syn_r       <= load_syn_s;
            corr_r      <= (load_syn_s != {P{1'b0}});
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef HAMMING_ERR_COUNT_EN
    logic [15:0] err_r;

    // Saturating count of loaded words that needed a correction.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 16'h0000;
        end else if (load_s && (load_syn_s != {P{1'b0}}) && (err_r != 16'hFFFF)) begin
            err_r <= err_r + 16'h0001;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.err_count = err_r;
`else
    assign bus.err_count = 16'h0000;
`endif

    assign bus.rx_ready  = rx_ready_r;
    assign bus.data_out  = data_r;
    assign bus.syndrome  = syn_r;
    assign bus.corrected = corr_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx (P=3): directed codewords with hand-computed
// decodes, back-pressure, continuous stream and mid-word reset.
module tb_hamming_serial_rx;
    localparam int P = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    hamming_serial_rx_if #(.P(P)) bus();
    hamming_serial_rx #(.P(P)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
    } exp_t;

    exp_t sb_q[$];

    // Stream vectors: clean words for each data basis, then single-bit errors.
    logic [6:0] stream_cw   [10] = '{7'h00, 7'h7F, 7'h07, 7'h19, 7'h2A, 7'h4B, 7'h3F, 7'h04, 7'h28, 7'h5D};
    logic [3:0] stream_data [10] = '{4'h0, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'h4, 4'hB};
    logic [2:0] stream_syn  [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd3, 3'd2, 3'd4};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    task automatic expect_word(input logic [3:0] d, input logic [2:0] s);
        exp_t e;
        e.data = d;
        e.syn  = s;
        e.corr = (s != 3'd0);
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted output is matched against the oldest expectation.
    int   exp_err = 0;
    int   pops = 0;
    bit   stream_mode = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_cyc = 0;
    exp_t m_e;

    always @(negedge clk) begin
        if (!stream_mode) have_prev = 1'b0;
        if (rst) begin
            exp_err = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", bus.data_out);
            end else begin
                m_e = sb_q.pop_front();
                pops++;
`ifdef HAMMING_ERR_COUNT_EN
                if (m_e.corr) exp_err++;
`endif
                check("data_out", 32'(bus.data_out), 32'(m_e.data));
                check("syndrome", 32'(bus.syndrome), 32'(m_e.syn));
                check("corrected", 32'(bus.corrected), 32'(m_e.corr));
                check("err_count", 32'(bus.err_count), 32'(exp_err));
                if (stream_mode) begin
                    if (have_prev) check("stream_spacing", 32'(cyc - prev_cyc), 32'd7);
                    have_prev = 1'b1;
                    prev_cyc  = cyc;
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        int g = 0;
        bus.rx_valid = 1'b1;
        bus.rx_bit   = b;
        while (!bus.rx_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [6:0] w);
        for (int i = 0; i < 7; i++) send_bit(w[i]);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_in_time", 32'(g < 100), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst           = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_bit    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        check("reset_syndrome", 32'(bus.syndrome), 32'd0);
        check("reset_corrected", 32'(bus.corrected), 32'd0);
        check("reset_err_count", 32'(bus.err_count), 32'd0);

        // Clean word, latency of one cycle after bit 6.
        expect_word(4'hB, 3'd0);
        send_word(7'h55);
        bus.rx_valid = 1'b0;
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        wait_drain();

        // Data-bit error and parity-bit error.
        expect_word(4'hB, 3'd5);
        send_word(7'h45);
        bus.rx_valid = 1'b0;
        wait_drain();
        expect_word(4'hB, 3'd1);
        send_word(7'h54);
        bus.rx_valid = 1'b0;
        wait_drain();

        // Back-pressure: second word parks in HOLD behind the first.
        bus.out_ready = 1'b0;
        expect_word(4'hB, 3'd0);
        expect_word(4'h2, 3'd0);
        send_word(7'h55);
        check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        send_word(7'h19);
        bus.rx_valid = 1'b0;
        check("bp_rx_ready_low", 32'(bus.rx_ready), 32'd0);
        check("bp_stable_data", 32'(bus.data_out), 32'hB);
        @(posedge clk); #1;
        check("bp_hold_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_data", 32'(bus.data_out), 32'hB);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("bp_second_valid", 32'(bus.out_valid), 32'd1);
        check("bp_second_data", 32'(bus.data_out), 32'h2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Continuous stream, rx_valid never drops between words.
        base = pops;
        stream_mode = 1'b1;
        for (int w = 0; w < 10; w++) begin
            expect_word(stream_data[w], stream_syn[w]);
            send_word(stream_cw[w]);
        end
        bus.rx_valid = 1'b0;
        wait_drain();
        stream_mode = 1'b0;
        check("stream_word_count", 32'(pops - base), 32'd10);

        // Reset after three bits discards the partial word.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_reset_err_count", 32'(bus.err_count), 32'd0);
        base = pops;
        expect_word(4'hB, 3'd0);
        send_word(7'h55);
        bus.rx_valid = 1'b0;
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        check("mid_reset_one_output", 32'(pops - base), 32'd1);
        check("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Serial receive stage directly upstream of the Hamming decoder. It shifts in a received Hamming(2^P−1, 2^P−P−1) codeword one bit per cycle and computes the syndrome. It single-error-corrects the word and presents the recovered data word on a valid/ready output handshake. It replaces the combinational error-injection path with a clocked, back-pressured channel front end, and optionally keeps a running corrected-error count.

## Interface
Parameters:
- P, 3, parity bit count; N = 2^P−1 codeword bits, K = 2^P−P−1 data bits

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  reset, synchronous and active-high
- rx_bit  in  1  serial codeword bit
- rx_valid  in  1  rx_bit is valid this cycle
- rx_ready  out  1  block accepts rx_bit this cycle
- data_out  out  K  corrected data word
- syndrome  out  P  syndrome of the word in data_out
- corrected  out  1  data_out required a single-bit correction (syndrome ≠ 0)
- out_valid  out  1  data_out, syndrome and corrected are valid
- out_ready  in  1  consumer takes the output this cycle
- err_count  out  16  corrected-word count (see Configuration)

## Operation
- Bit order: codeword index 0 (position 1) arrives first, and index N−1 arrives last.
- Layout is positional:
  - Parity bits sit at positions 2^j.
  - Data bits fill the remaining positions in ascending order, with data[0] at the lowest of them.
  - This matches hamming_7_4_encoder.
- A transfer on the input side occurs when rx_valid && rx_ready. Shift register sr[N−1:0] and bit counter cnt (0..N−1) advance only on a transfer.
- Syndrome s is the XOR of (i+1) over every set bit i of the completed word.
  - If s ≠ 0, bit s−1 is inverted before data extraction.
  - Every nonzero s is a legal position.
  - Double errors are miscorrected silently; this is accepted behaviour.
- FSM has two states:
  - SHIFT: rx_ready = 1.
    - On the transfer with cnt == N−1, the completed word is sr plus the incoming bit.
    - If the output register is free (out_valid == 0, or out_valid && out_ready this cycle), the decoded result loads the output register at that edge. cnt returns to 0 and the FSM stays in SHIFT.
    - Otherwise the completed word is held in sr and the FSM goes to HOLD.
  - HOLD: rx_ready = 0.
    - When out_valid && out_ready, the held word's decode loads the output register at that edge. out_valid stays 1, cnt goes to 0, and the FSM returns to SHIFT.
- Output register:
  - Cleared (out_valid = 0) on out_valid && out_ready with no simultaneous load.
  - Contents are stable while out_valid && !out_ready.
- rx_bit is ignored when rx_valid = 0 or rx_ready = 0.

## Timing
- Reset values:
  - FSM = SHIFT, cnt = 0, sr = 0, rx_ready = 1.
  - out_valid = 0, data_out = 0, syndrome = 0, corrected = 0, err_count = 0.
- Reset mid-word discards any partial or held word. There is no output on the cycle after reset.
- Latency: out_valid rises on the cycle after the Nth bit transfer when the output register is free.
- Throughput: one word per N cycles with out_ready held high, with no bubbles between words.
- Simultaneous Nth-bit transfer and output drain: the new word loads and out_valid stays high.
- rx_ready depends only on registered state. There is no combinational path from out_ready to rx_ready.

## Configuration
HAMMING_ERR_COUNT_EN:
- Defined:
  - err_count increments by 1 at each output-register load with syndrome ≠ 0.
  - It saturates at 16'hFFFF and clears only on rst.
- Undefined:
  - err_count is constant 0 and no counter logic is built.
  - The port remains so the interface is fixed.

## Test plan
All scenarios use P = 3 (N = 7, K = 4). Data 4'b1011 encodes to codeword 7'h55 (bits[6:0] = 1010101).
- Clean word: send 7'h55, bit 0 first, with out_ready = 1 → out_valid one cycle after bit 6; data_out = 4'b1011, syndrome = 0, corrected = 0; err_count unchanged.
- Single error: send 7'h45 (bit index 4 flipped) → data_out = 4'b1011, syndrome = 3'd5, corrected = 1; err_count = 1 with the macro, 0 without.
- Parity-bit error: send 7'h54 (bit 0 flipped) → data_out = 4'b1011, syndrome = 1, corrected = 1.
- Back-pressure:
  - Setup: out_ready = 0 while two words are sent back to back.
  - Response: the first word is presented and stable; after bit 6 of the second word, rx_ready = 0.
  - Release: raising out_ready for one cycle drains the first word, loads the second, and rx_ready returns to 1 on the next cycle.
- Continuous stream: 10 words with rx_valid and out_ready held high → 10 out_valid pulses spaced 7 cycles apart, each with correct data and no dropped bits.
- Reset mid-word: assert rst after 3 bits, then send a full 7'h55 → exactly one output with data_out = 4'b1011; the partial word produces nothing.
